// File: rtl/program_loader_if.sv
// Byte-stream and memory write-port bundle for program_loader.
// master: the loader (consumes bytes, drives memory writes).
// slave : the environment (byte source and memory).
interface program_loader_if #(
   parameter int ADDR_W = 12
) ();
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;

   modport master (
      input  in_valid, in_data, mem_ack,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_data, mem_ack,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes
// them from word address 0 upward, then holds the core in reset for
// RST_HOLD cycles before releasing it.
// Optional feature macro: LOADER_CHECKSUM_EN -- after the last word, four
// more bytes carry a little-endian 32-bit wrapping sum of all written words;
// a mismatch flags err and returns to IDLE with the core kept in reset.
//
// state  | meaning
// IDLE   | waiting for start, core held in reset
// RECV   | accepting bytes into the current word (or checksum)
// WRITE  | word write pending on the memory port until mem_ack
// HOLD   | image complete, core still in reset for RST_HOLD cycles
// DONE   | core released, load finished
module program_loader #(
   parameter int DEPTH_WORDS = 4096,
   parameter int ADDR_W      = 12,
   parameter int RST_HOLD    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W:0]   len_words_i,
   program_loader_if.master  bus,
   output logic              core_rst_n_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH_WORDS);
   localparam logic [ADDR_W:0] ONE_W     = (ADDR_W+1)'(1);
   localparam logic [7:0]      HOLD_LOAD = 8'(RST_HOLD - 1);

   state_t            state_q;
   logic              in_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              core_rst_n_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [1:0]        byte_cnt_q;
   logic [ADDR_W:0]   word_cnt_q;
   logic [ADDR_W:0]   len_q;
   logic [7:0]        hold_cnt_q;
   logic [ADDR_W:0]   word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       sum_q;
   logic [31:0]       chk_q;
   logic              chk_phase_q;
`endif

   assign word_cnt_d = word_cnt_q + ONE_W;

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign core_rst_n_o  = core_rst_n_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

   // Load sequencer: all outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         byte_cnt_q   <= '0;
         word_cnt_q   <= '0;
         len_q        <= '0;
         hold_cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= '0;
         chk_q        <= '0;
         chk_phase_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  done_q       <= 1'b0;
                  core_rst_n_q <= 1'b0;
                  byte_cnt_q   <= '0;
                  word_cnt_q   <= '0;
                  mem_addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum_q        <= '0;
                  chk_phase_q  <= 1'b0;
`endif
                  if (len_words_i == '0) begin
                     err_q      <= 1'b0;
                     busy_q     <= 1'b1;
                     hold_cnt_q <= HOLD_LOAD;
                     state_q    <= ST_HOLD;
                  end else if (len_words_i > DEPTH_L) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     len_q      <= len_words_i;
                     err_q      <= 1'b0;
                     busy_q     <= 1'b1;
                     in_ready_q <= 1'b1;
                     state_q    <= ST_RECV;
                  end
               end
            end

            ST_RECV: begin
               if (bus.in_valid && in_ready_q) begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  if (chk_phase_q) begin
                     chk_q[{byte_cnt_q, 3'b000} +: 8] <= bus.in_data;
                     if (byte_cnt_q == 2'd3) begin
                        in_ready_q <= 1'b0;
                        if ({bus.in_data, chk_q[23:0]} == sum_q) begin
                           hold_cnt_q <= HOLD_LOAD;
                           state_q    <= ST_HOLD;
                        end else begin
                           err_q   <= 1'b1;
                           busy_q  <= 1'b0;
                           state_q <= ST_IDLE;
                        end
                     end
                  end else begin
                     mem_wdata_q[{byte_cnt_q, 3'b000} +: 8] <= bus.in_data;
                     if (byte_cnt_q == 2'd3) begin
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                        state_q    <= ST_WRITE;
                     end
                  end
`else
                  mem_wdata_q[{byte_cnt_q, 3'b000} +: 8] <= bus.in_data;
                  if (byte_cnt_q == 2'd3) begin
                     in_ready_q <= 1'b0;
                     mem_we_q   <= 1'b1;
                     state_q    <= ST_WRITE;
                  end
`endif
               end
            end

            ST_WRITE: begin
               if (mem_we_q && bus.mem_ack) begin
                  mem_we_q   <= 1'b0;
                  word_cnt_q <= word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
                  sum_q      <= sum_q + mem_wdata_q;
`endif
                  if (word_cnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                     chk_phase_q <= 1'b1;
                     in_ready_q  <= 1'b1;
                     state_q     <= ST_RECV;
`else
                     hold_cnt_q <= HOLD_LOAD;
                     state_q    <= ST_HOLD;
`endif
                  end else begin
                     mem_addr_q <= word_cnt_d[ADDR_W-1:0];
                     in_ready_q <= 1'b1;
                     state_q    <= ST_RECV;
                  end
               end
            end

            ST_HOLD: begin
               if (hold_cnt_q == 8'd0) begin
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  core_rst_n_q <= 1'b1;
                  state_q      <= ST_DONE;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 8'd1;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of load scenarios plus randomized loads,
// checked against a byte-list -> word-list model, and hand sequences for
// mid-load reset and checksum mismatch.
module tb_program_loader;
   localparam int DEPTH    = 4096;
   localparam int ADDR_W   = 12;
   localparam int RST_HOLD = 4;

   typedef struct {
      int          len;
      bit          fixed;
      int          ack_dly;
      bit          tog;
      bit          exp_err;
      bit          exp_done;
      int          exp_nwr;
      logic [31:0] exp_w0;
      logic [31:0] exp_w1;
   } vec_t;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [ADDR_W:0] len_words;
   logic            core_rst_n, busy, done, err;

   program_loader_if #(.ADDR_W(ADDR_W)) bus ();

   program_loader #(
      .DEPTH_WORDS(DEPTH),
      .ADDR_W     (ADDR_W),
      .RST_HOLD   (RST_HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .len_words_i (len_words),
      .bus         (bus),
      .core_rst_n_o(core_rst_n),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] src_q[$];
   wr_t        wr_q[$];
   bit         tog_mode    = 0;
   bit         tog_phase   = 0;
   bit         popped_last = 0;
   bit         ack_tied    = 1;
   int         ack_delay   = 0;
   int         wait_cnt    = 0;
   int         consumed    = 0;
   int         we_cycles   = 0;
   int         unstable    = 0;
   int         rdy_in_wr   = 0;
   int         cyc         = 0;
   int         last_evt    = 0;
   bit          prev_wait  = 0;
   logic [ADDR_W-1:0] prev_addr;
   logic [31:0]       prev_data;

   logic [7:0] fixed_bytes[8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Byte source, memory responder and bus monitor, all on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.in_valid = 1'b0;
         bus.in_data  = 8'h00;
         bus.mem_ack  = 1'b0;
         popped_last  = 0;
         wait_cnt     = 0;
         prev_wait    = 0;
      end else begin
         if (popped_last) begin
            void'(src_q.pop_front());
            consumed++;
         end
         if (src_q.size() > 0 && (!tog_mode || tog_phase)) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src_q[0];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
         end
         tog_phase   = !tog_phase;
         popped_last = bus.in_valid && bus.in_ready;
         if (popped_last) last_evt = cyc + 1;

         if (prev_wait && (!bus.mem_we || bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_data))
            unstable++;
         if (bus.mem_we) begin
            we_cycles++;
            if (bus.in_ready) rdy_in_wr++;
            if (ack_tied || wait_cnt >= ack_delay) begin
               bus.mem_ack = 1'b1;
               wr_q.push_back('{int'(bus.mem_addr), bus.mem_wdata});
               last_evt = cyc + 1;
            end else begin
               bus.mem_ack = 1'b0;
               wait_cnt++;
            end
            prev_wait = !bus.mem_ack;
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_wdata;
         end else begin
            bus.mem_ack = ack_tied;
            wait_cnt    = 0;
            prev_wait   = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(input int len);
      len_words = (ADDR_W+1)'(len);
      start     = 1'b1;
      last_evt  = cyc + 1;
      tick();
      start     = 1'b0;
      len_words = (ADDR_W+1)'($urandom);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      logic [7:0]  img[$];
      logic [31:0] words[$];
      logic [31:0] w;
      logic [31:0] sum;
      int          bad;
      int          n;
      int          budget;
      int          bad_busy;
      wr_q.delete();
      we_cycles = 0;
      unstable  = 0;
      rdy_in_wr = 0;
      ack_tied  = (v.ack_dly == 0);
      ack_delay = v.ack_dly;
      tog_mode  = v.tog;
      sum       = '0;
      if (v.len <= DEPTH) begin
         for (int i = 0; i < v.len * 4; i++)
            img.push_back(v.fixed ? fixed_bytes[i % 8] : 8'($urandom));
         for (int i = 0; i < v.len; i++) begin
            w = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
            words.push_back(w);
            sum = sum + w;
         end
`ifdef LOADER_CHECKSUM_EN
         if (v.len > 0)
            for (int k = 0; k < 4; k++) img.push_back(sum[8*k +: 8]);
`endif
      end
      foreach (img[i]) src_q.push_back(img[i]);
      pulse_start(v.len);
      if (v.exp_err) begin
         repeat (8) tick();
         check({tag, "_err"}, 64'(err), 64'(v.exp_err));
         check({tag, "_done"}, 64'(done), 64'(v.exp_done));
         check({tag, "_busy"}, 64'(busy), 64'd0);
         check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
         check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
         check({tag, "_we_cycles"}, 64'(we_cycles), 64'd0);
      end else begin
         budget   = 6 * (v.len + 2) * (v.ack_dly + 2) + 50;
         n        = 0;
         bad_busy = 0;
         while (!done && n < budget) begin
            if (!(busy === 1'b1 && core_rst_n === 1'b0)) bad_busy++;
            tick();
            n++;
         end
         check({tag, "_done"}, 64'(done), 64'(v.exp_done));
         check({tag, "_hold_latency"}, 64'(cyc - last_evt), 64'(RST_HOLD));
         check({tag, "_busy_during"}, 64'(bad_busy), 64'd0);
         check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd1);
         check({tag, "_busy_after"}, 64'(busy), 64'd0);
         check({tag, "_err"}, 64'(err), 64'd0);
         check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
         check({tag, "_nwr"}, 64'(wr_q.size()), 64'(v.exp_nwr));
         bad = 0;
         for (int i = 0; i < wr_q.size() && i < words.size(); i++)
            if (wr_q[i].addr != i || wr_q[i].data !== words[i]) bad++;
         check({tag, "_image_bad_words"}, 64'(bad), 64'd0);
         check({tag, "_hold_stable"}, 64'(unstable), 64'd0);
         check({tag, "_ready_in_write"}, 64'(rdy_in_wr), 64'd0);
         check({tag, "_bytes_left"}, 64'(src_q.size()), 64'd0);
         if (v.fixed && wr_q.size() > 0) check({tag, "_w0"}, 64'(wr_q[0].data), 64'(v.exp_w0));
         if (v.fixed && wr_q.size() > 1) check({tag, "_w1"}, 64'(wr_q[1].data), 64'(v.exp_w1));
      end
      src_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
      check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
      check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
   endtask

   vec_t tbl[7];
   vec_t rv;
   int   base;
   int   n;

   initial begin
      tbl[0] = '{2,    1, 0, 0, 0, 1, 2,    32'h00000513, 32'h00100593};
      tbl[1] = '{2,    1, 3, 0, 0, 1, 2,    32'h00000513, 32'h00100593};
      tbl[2] = '{1,    1, 0, 1, 0, 1, 1,    32'h00000513, 32'h0};
      tbl[3] = '{4097, 0, 0, 0, 1, 0, 0,    32'h0,        32'h0};
      tbl[4] = '{0,    0, 0, 0, 0, 1, 0,    32'h0,        32'h0};
      tbl[5] = '{4096, 0, 0, 0, 0, 1, 4096, 32'h0,        32'h0};
      tbl[6] = '{3,    0, 1, 1, 0, 1, 3,    32'h0,        32'h0};

      start     = 1'b0;
      len_words = '0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      repeat (3) tick();
      check_reset_vals("reset");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), tbl[i]);

      for (int i = 0; i < 6; i++) begin
         rv = '{$urandom_range(1, 6), 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                0, 1, 0, 32'h0, 32'h0};
         rv.exp_nwr = rv.len;
         run_vec($sformatf("rnd%0d", i), rv);
      end

      // Reset in the middle of word 1: word 0 written, two bytes of word 1 taken.
      wr_q.delete();
      ack_tied = 1;
      tog_mode = 0;
      for (int i = 0; i < 6; i++) src_q.push_back(fixed_bytes[i]);
      base = consumed;
      pulse_start(2);
      n = 0;
      while (consumed - base < 6 && n < 200) begin
         tick();
         n++;
      end
      check("midrst_bytes_taken", 64'(consumed - base), 64'd6);
      check("midrst_writes_before", 64'(wr_q.size()), 64'd1);
      check("midrst_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      tick();
      rst_n = 1'b1;
      src_q.delete();
      tick();
      run_vec("reload", tbl[2]);

`ifdef LOADER_CHECKSUM_EN
      // Checksum mismatch: word 0x00000513 followed by 14 05 00 00.
      wr_q.delete();
      ack_tied = 1;
      tog_mode = 0;
      for (int i = 0; i < 4; i++) src_q.push_back(fixed_bytes[i]);
      src_q.push_back(8'h14);
      src_q.push_back(8'h05);
      src_q.push_back(8'h00);
      src_q.push_back(8'h00);
      pulse_start(1);
      n = 0;
      while (!err && !done && n < 200) begin
         tick();
         n++;
      end
      repeat (RST_HOLD + 2) tick();
      check("badchk_err", 64'(err), 64'd1);
      check("badchk_core_rst_n", 64'(core_rst_n), 64'd0);
      check("badchk_done", 64'(done), 64'd0);
      check("badchk_busy", 64'(busy), 64'd0);
      check("badchk_nwr", 64'(wr_q.size()), 64'd1);
      src_q.delete();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
